// File: rtl/fft_frame_serializer_if.sv
// ---------------------------------------------------------------------------
// fft_frame_serializer_if
// Bundles the parallel frame input and the serial sample output of the
// FFT frame serializer.
//   frame_valid / frame_ready : frame capture handshake
//   frame_r / frame_i         : NPTS packed samples, point k at [k*DW +: DW]
//   bitrev_en                 : emission order select, sampled at capture
//   out_valid / out_ready     : per-sample output handshake
//   out_r / out_i             : emitted sample
//   out_index                 : frame index of the emitted sample
//   out_last                  : final sample of the frame
//   frame_cnt                 : number of fully emitted frames (wrapping)
// Modports: master = environment (frame source + sample sink),
//           slave  = serializer.
// ---------------------------------------------------------------------------
interface fft_frame_serializer_if #(
   parameter int DW   = 32,
   parameter int NPTS = 32
);
   logic                 frame_valid;
   logic                 frame_ready;
   logic [NPTS*DW-1:0]   frame_r;
   logic [NPTS*DW-1:0]   frame_i;
   logic                 bitrev_en;
   logic                 out_valid;
   logic                 out_ready;
   logic [DW-1:0]        out_r;
   logic [DW-1:0]        out_i;
   logic [4:0]           out_index;
   logic                 out_last;
   logic [15:0]          frame_cnt;

   modport master (
      output frame_valid, frame_r, frame_i, bitrev_en, out_ready,
      input  frame_ready, out_valid, out_r, out_i, out_index, out_last, frame_cnt
   );

   modport slave (
      input  frame_valid, frame_r, frame_i, bitrev_en, out_ready,
      output frame_ready, out_valid, out_r, out_i, out_index, out_last, frame_cnt
   );
endinterface

// File: rtl/fft_frame_serializer.sv
// ---------------------------------------------------------------------------
// fft_frame_serializer
// Captures a parallel 32-point complex FFT result frame and emits it one
// point per accepted transfer, in natural or bit-reversed index order.
// Ports:
//   clk   : rising-edge clock
//   reset : asynchronous active-low reset
//   bus   : fft_frame_serializer_if.slave (frame input, sample output,
//           completed-frame counter)
// ---------------------------------------------------------------------------
module fft_frame_serializer #(
   parameter int DW   = 32,
   parameter int NPTS = 32
) (
   input  logic                    clk,
   input  logic                    reset,
   fft_frame_serializer_if.slave   bus
);

   localparam int IW = 5;
   localparam logic [IW-1:0] LAST_SEQ = IW'(NPTS - 1);

   typedef enum logic {IDLE, STREAM} state_t;

   state_t        state;
   logic          ready_q;
   logic          bitrev_q;
   logic [IW-1:0] seq;
   logic [15:0]   frame_cnt_q;
   logic          out_valid_q;
   logic          out_last_q;
   logic [IW-1:0] out_index_q;
   logic [DW-1:0] out_r_q;
   logic [DW-1:0] out_i_q;

   logic [DW-1:0] buf_r [NPTS];
   logic [DW-1:0] buf_i [NPTS];

   logic          capture;
   logic          xfer;
   logic [IW-1:0] nxt_seq;
   logic [IW-1:0] nxt_idx;

   function automatic logic [IW-1:0] bit_rev(input logic [IW-1:0] v);
      logic [IW-1:0] r;
      for (int b = 0; b < IW; b++) begin
         r[b] = v[IW-1-b];
      end
      return r;
   endfunction

   // frame_ready is held low for as long as reset is asserted
   assign bus.frame_ready = ready_q & reset;
   assign bus.out_valid   = out_valid_q;
   assign bus.out_last    = out_last_q;
   assign bus.out_index   = out_index_q;
   assign bus.out_r       = out_r_q;
   assign bus.out_i       = out_i_q;
   assign bus.frame_cnt   = frame_cnt_q;

   assign capture = bus.frame_valid & bus.frame_ready;
   assign xfer    = out_valid_q & bus.out_ready;
   assign nxt_seq = seq + 1'b1;
   assign nxt_idx = bitrev_q ? bit_rev(nxt_seq) : nxt_seq;

   // ---- capture stage: frame buffer (data only, never reset) ----
   always_ff @(posedge clk) begin
      if (capture) begin
         for (int k = 0; k < NPTS; k++) begin
            buf_r[k] <= bus.frame_r[k*DW +: DW];
            buf_i[k] <= bus.frame_i[k*DW +: DW];
         end
      end
   end

   // ---- output stage: sequencing FSM and registered sample ----
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state       <= IDLE;
         ready_q     <= 1'b1;
         bitrev_q    <= 1'b0;
         seq         <= '0;
         frame_cnt_q <= '0;
         out_valid_q <= 1'b0;
         out_last_q  <= 1'b0;
         out_index_q <= '0;
         out_r_q     <= '0;
         out_i_q     <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (capture) begin
                  state       <= STREAM;
                  ready_q     <= 1'b0;
                  bitrev_q    <= bus.bitrev_en;
                  seq         <= '0;
                  out_valid_q <= 1'b1;
                  out_last_q  <= 1'b0;
                  // index 0 maps to itself in both orders, so the first
                  // sample is taken straight from the bus while the buffer
                  // is being loaded on the same edge
                  out_index_q <= '0;
                  out_r_q     <= bus.frame_r[DW-1:0];
                  out_i_q     <= bus.frame_i[DW-1:0];
               end
            end
            STREAM: begin
               if (xfer) begin
                  if (seq == LAST_SEQ) begin
                     state       <= IDLE;
                     ready_q     <= 1'b1;
                     out_valid_q <= 1'b0;
                     out_last_q  <= 1'b0;
                     frame_cnt_q <= frame_cnt_q + 16'd1;
                  end else begin
                     seq         <= nxt_seq;
                     out_index_q <= nxt_idx;
                     out_r_q     <= buf_r[nxt_idx];
                     out_i_q     <= buf_i[nxt_idx];
                     out_last_q  <= (nxt_seq == LAST_SEQ);
                  end
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_fft_frame_serializer.sv
// ---------------------------------------------------------------------------
// tb_fft_frame_serializer
// Self-checking bench for fft_frame_serializer. Expected emission order is
// built by recursive doubling of the index list; expected data comes from
// the frame arrays the bench itself generated.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_fft_frame_serializer;

   localparam int DW = 32;
   localparam int NP = 32;

   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   fft_frame_serializer_if #(.DW(DW), .NPTS(NP)) bus();

   fft_frame_serializer #(.DW(DW), .NPTS(NP)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   int total = 0;
   int bad   = 0;
   logic [15:0]   model_cnt;
   logic [DW-1:0] fr   [NP];
   logic [DW-1:0] fi   [NP];
   logic [DW-1:0] nb_r [NP];
   logic [DW-1:0] nb_i [NP];
   int            order[NP];

   typedef struct {
      bit          br;
      int          pct;
      bit          rnd;
      logic [15:0] exp_cnt;
   } vec_t;
   vec_t tab[6];

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   // Bit-reversed permutation by doubling: each pass maps list L to
   // {2*L, 2*L+1}.
   task automatic build_order(input bit br);
      int tmp[NP];
      int len;
      if (!br) begin
         for (int k = 0; k < NP; k++) order[k] = k;
      end else begin
         order[0] = 0;
         len = 1;
         while (len < NP) begin
            for (int i = 0; i < len; i++) begin
               tmp[i]       = 2 * order[i];
               tmp[i + len] = 2 * order[i] + 1;
            end
            for (int i = 0; i < 2 * len; i++) order[i] = tmp[i];
            len = len * 2;
         end
      end
   endtask

   task automatic fill_kk();
      for (int k = 0; k < NP; k++) begin
         fr[k] = DW'(k);
         fi[k] = DW'(-k);
      end
   endtask

   task automatic fill_rand();
      for (int k = 0; k < NP; k++) begin
         fr[k] = DW'($urandom());
         fi[k] = DW'($urandom());
      end
   endtask

   task automatic pack(input bit use_nb);
      for (int k = 0; k < NP; k++) begin
         bus.frame_r[k*DW +: DW] = use_nb ? nb_r[k] : fr[k];
         bus.frame_i[k*DW +: DW] = use_nb ? nb_i[k] : fi[k];
      end
   endtask

   task automatic garbage();
      for (int k = 0; k < NP; k++) begin
         bus.frame_r[k*DW +: DW] = DW'($urandom());
         bus.frame_i[k*DW +: DW] = DW'($urandom());
      end
   endtask

   // Starts just after a falling edge, ends just after a falling edge.
   task automatic run_frame(input bit br, input int pct, input bit hold_next,
                            input int abort_at, output int wait_cyc);
      int n;
      int cyc;
      int idx;
      build_order(br);
      pack(1'b0);
      bus.bitrev_en   = br;
      bus.frame_valid = 1'b1;
      cyc = 0;
      while (!bus.frame_ready && cyc < 100) begin
         @(negedge clk);
         cyc++;
      end
      wait_cyc = cyc;
      chk("capture_ready", {63'd0, bus.frame_ready}, 64'd1);
      @(posedge clk);
      n = 0;
      cyc = 0;
      while (n < NP && cyc < 4000) begin
         #1;
         if (abort_at >= 0 && n == abort_at) begin
            reset = 1'b0;
            #1;
            chk("rst_out_valid", {63'd0, bus.out_valid}, 64'd0);
            chk("rst_frame_ready", {63'd0, bus.frame_ready}, 64'd0);
            chk("rst_out_index", {59'd0, bus.out_index}, 64'd0);
            chk("rst_out_r", {32'd0, bus.out_r}, 64'd0);
            chk("rst_out_last", {63'd0, bus.out_last}, 64'd0);
            chk("rst_frame_cnt", {48'd0, bus.frame_cnt}, 64'd0);
            model_cnt = 16'd0;
            bus.out_ready = 1'b0;
            @(negedge clk);
            reset = 1'b1;
            #1;
            chk("rst_release_ready", {63'd0, bus.frame_ready}, 64'd1);
            return;
         end
         if (cyc == 0) begin
            bus.bitrev_en = ~br;
            if (hold_next) begin
               pack(1'b1);
               bus.frame_valid = 1'b1;
            end else begin
               garbage();
               bus.frame_valid = 1'b0;
            end
         end
         bus.out_ready = (int'($urandom_range(0, 99)) < pct);
         @(negedge clk);
         chk("stream_valid", {63'd0, bus.out_valid}, 64'd1);
         chk("stream_ready_low", {63'd0, bus.frame_ready}, 64'd0);
         idx = order[n];
         chk("out_index", {59'd0, bus.out_index}, 64'(idx));
         chk("out_r", {32'd0, bus.out_r}, {32'd0, fr[idx]});
         chk("out_i", {32'd0, bus.out_i}, {32'd0, fi[idx]});
         chk("out_last", {63'd0, bus.out_last}, (n == NP - 1) ? 64'd1 : 64'd0);
         if (bus.out_valid && bus.out_ready) n++;
         @(posedge clk);
         cyc++;
      end
      if (n < NP) chk("frame_transfers", 64'(n), 64'(NP));
      else model_cnt = model_cnt + 16'd1;
      #1;
      bus.out_ready = 1'b0;
      @(negedge clk);
      chk("idle_valid", {63'd0, bus.out_valid}, 64'd0);
      chk("idle_ready", {63'd0, bus.frame_ready}, 64'd1);
      chk("idle_last", {63'd0, bus.out_last}, 64'd0);
      chk("frame_cnt", {48'd0, bus.frame_cnt}, {48'd0, model_cnt});
   endtask

   initial begin
      #5_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int w;
      tab[0] = '{br: 1'b0, pct: 100, rnd: 1'b0, exp_cnt: 16'd1};
      tab[1] = '{br: 1'b1, pct: 100, rnd: 1'b0, exp_cnt: 16'd2};
      tab[2] = '{br: 1'b0, pct: 30,  rnd: 1'b0, exp_cnt: 16'd3};
      tab[3] = '{br: 1'b1, pct: 30,  rnd: 1'b1, exp_cnt: 16'd4};
      tab[4] = '{br: 1'b0, pct: 70,  rnd: 1'b1, exp_cnt: 16'd5};
      tab[5] = '{br: 1'b1, pct: 100, rnd: 1'b1, exp_cnt: 16'd6};

      model_cnt       = 16'd0;
      reset           = 1'b0;
      bus.frame_valid = 1'b0;
      bus.bitrev_en   = 1'b0;
      bus.out_ready   = 1'b0;
      bus.frame_r     = '0;
      bus.frame_i     = '0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("reset_out_valid", {63'd0, bus.out_valid}, 64'd0);
      chk("reset_frame_ready", {63'd0, bus.frame_ready}, 64'd0);
      chk("reset_out_last", {63'd0, bus.out_last}, 64'd0);
      chk("reset_out_index", {59'd0, bus.out_index}, 64'd0);
      chk("reset_out_r", {32'd0, bus.out_r}, 64'd0);
      chk("reset_out_i", {32'd0, bus.out_i}, 64'd0);
      chk("reset_frame_cnt", {48'd0, bus.frame_cnt}, 64'd0);
      reset = 1'b1;
      #1;
      chk("ready_after_reset", {63'd0, bus.frame_ready}, 64'd1);

      for (int t = 0; t < 6; t++) begin
         if (tab[t].rnd) fill_rand();
         else fill_kk();
         run_frame(tab[t].br, tab[t].pct, 1'b0, -1, w);
         chk("table_frame_cnt", {48'd0, bus.frame_cnt}, {48'd0, tab[t].exp_cnt});
      end

      // New frame held on the bus during streaming: ignored until the
      // cycle after the last transfer, then captured immediately.
      fill_kk();
      for (int k = 0; k < NP; k++) begin
         nb_r[k] = DW'($urandom());
         nb_i[k] = DW'($urandom());
      end
      run_frame(1'b0, 100, 1'b1, -1, w);
      for (int k = 0; k < NP; k++) begin
         fr[k] = nb_r[k];
         fi[k] = nb_i[k];
      end
      run_frame(1'b1, 100, 1'b0, -1, w);
      chk("busy_capture_wait", 64'(w), 64'd0);
      chk("busy_frame_cnt", {48'd0, bus.frame_cnt}, 64'd8);

      // Reset after 10 transfers, then a clean frame from index 0.
      fill_kk();
      run_frame(1'b0, 100, 1'b0, 10, w);
      run_frame(1'b0, 100, 1'b0, -1, w);
      chk("post_reset_cnt", {48'd0, bus.frame_cnt}, 64'd1);

      // Counter wrap.
      force dut.frame_cnt_q = 16'hFFFF;
      #1;
      release dut.frame_cnt_q;
      model_cnt = 16'hFFFF;
      fill_rand();
      run_frame(1'b1, 50, 1'b0, -1, w);
      chk("wrap_cnt", {48'd0, bus.frame_cnt}, 64'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
